lfsr_csr_slave: RTL

- UDM bus slave (MemSplit32 slave-side signals) that produces a buffered stream of 32-bit Galois LFSR words.
- Sits directly downstream of the udm master in the NEXYS4_DDR top, alongside the LED/SW CSRs; its resp/rdata are OR-combined into the shared response.
- Host writes a seed and run control, then pops generated words one per DATA read.
- A small sync FIFO decouples generation from bursty UART read rate.

---
 rtl/lfsr_csr_pkg.sv | 16 +
 rtl/lfsr_sync_fifo.sv | 42 ++++
 rtl/lfsr_csr_slave.sv | 107 ++++++++++
 3 files changed

// File: rtl/lfsr_csr_pkg.sv
// lfsr_csr_pkg: register map, CTRL bit positions, default feedback mask and generator states for lfsr_csr_slave.
package lfsr_csr_pkg;
  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_SEED    = 5'h04;
  localparam logic [4:0] OFF_STATUS  = 5'h08;
  localparam logic [4:0] OFF_DATA    = 5'h0C;
  localparam logic [4:0] OFF_GEN_CNT = 5'h10;
  localparam int CTRL_RUN   = 0;
  localparam int CTRL_STEP  = 1;
  localparam int CTRL_FLUSH = 2;
  localparam logic [31:0] DEF_POLY = 32'h80200003;
  typedef enum logic [1:0] {IDLE, RUN, STALL} gen_state_t;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] poly);
    return s[0] ? (s >> 1) ^ poly : s >> 1;
  endfunction
endpackage

// File: rtl/lfsr_sync_fifo.sv
// lfsr_sync_fifo: synchronous first-word-fall-through FIFO with flush; a push into a full FIFO is accepted when a pop happens on the same edge.
module lfsr_sync_fifo #(
  parameter int W  = 32,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);
  localparam int D = 1 << AW;
  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == (AW+1)'(D);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rp];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  always_ff @(posedge clk_i) begin
    if (rst_i || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/lfsr_csr_slave.sv
// lfsr_csr_slave: UDM bus slave streaming Galois LFSR words through a small FIFO, one word per DATA read.
// Define LFSR_CSR_GEN_CNT_EN to add the GEN_CNT pushed-word counter at offset 0x10.
module lfsr_csr_slave import lfsr_csr_pkg::*; #(
  parameter logic [31:0] BASE_ADDR      = 32'h00000010,
  parameter int          FIFO_DEPTH_POW = 3,
  parameter logic [31:0] POLY           = DEF_POLY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        hit_o
);
  localparam int CW = FIFO_DEPTH_POW + 1;
  logic [31:0]   w_off, w_head, w_rd_val, w_gen_cnt, w_status;
  logic [31:0]   r_lfsr, r_rdata;
  logic [4:0]    w_reg;
  logic [CW-1:0] w_count;
  logic          w_rd, w_wr, w_wr_ctrl, w_wr_seed, w_flush, w_step, w_gen, w_push, w_pop;
  logic          w_full, w_empty, w_uflow_set, w_uflow_clr;
  logic          r_uflow, r_resp;
  gen_state_t    r_state, w_state_nxt;
  // Subtracting the base lets one unsigned compare reject addresses on both sides of the window.
  assign w_off       = bus_addr_bi - BASE_ADDR;
  assign hit_o       = w_off < 32'd20;
  assign bus_ack_o   = bus_req_i & hit_o;
  assign w_reg       = {w_off[4:2], 2'b00};
  assign w_rd        = bus_ack_o & ~bus_we_i;
  assign w_wr        = bus_ack_o & bus_we_i & |bus_be_bi;
  assign w_wr_ctrl   = w_wr & (w_reg == OFF_CTRL);
  assign w_wr_seed   = w_wr & (w_reg == OFF_SEED);
  assign w_flush     = w_wr_seed | (w_wr_ctrl & bus_wdata_bi[CTRL_FLUSH]);
  assign w_step      = w_wr_ctrl & bus_wdata_bi[CTRL_STEP];
  assign w_pop       = w_rd & (w_reg == OFF_DATA) & ~w_empty;
  assign w_uflow_set = w_rd & (w_reg == OFF_DATA) & w_empty;
  assign w_uflow_clr = w_rd & (w_reg == OFF_STATUS);
  // A full FIFO still takes a word when the head leaves on the same edge, keeping the stream gap-free.
  assign w_gen       = (r_state == IDLE ? w_step : 1'b1) & (~w_full | w_pop);
  assign w_push      = w_gen & ~w_flush;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_wr_ctrl ? (bus_wdata_bi[CTRL_RUN] ? RUN : IDLE) :
                  r_state == IDLE ? IDLE :
                  (w_full & ~w_pop) ? STALL : RUN;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_lfsr <= 32'd1;
    else if (w_wr_seed) r_lfsr <= (bus_wdata_bi == '0) ? 32'd1 : bus_wdata_bi;
    else if (w_push) r_lfsr <= lfsr_next(r_lfsr, POLY);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_uflow <= 1'b0;
    else r_uflow <= w_uflow_set | (r_uflow & ~w_uflow_clr);
  end
  lfsr_sync_fifo #(.W(32), .AW(FIFO_DEPTH_POW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (r_lfsr),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
`ifdef LFSR_CSR_GEN_CNT_EN
  logic [31:0] r_gen_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i || w_wr_seed || (w_wr && w_reg == OFF_GEN_CNT)) r_gen_cnt <= '0;
    else if (w_push) r_gen_cnt <= r_gen_cnt + 32'd1;
  end
  assign w_gen_cnt = r_gen_cnt;
`else
  assign w_gen_cnt = '0;
`endif
  assign w_status = {16'b0, 8'(w_count), 5'b0, r_uflow, w_full, w_empty};
  always_comb begin
    w_rd_val = '0;
    w_rd_val = w_reg == OFF_CTRL    ? {31'b0, r_state != IDLE} :
               w_reg == OFF_SEED    ? r_lfsr :
               w_reg == OFF_STATUS  ? w_status :
               w_reg == OFF_DATA    ? (w_empty ? 32'b0 : w_head) :
               w_reg == OFF_GEN_CNT ? w_gen_cnt : 32'b0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_resp  <= w_rd;
      r_rdata <= w_rd ? w_rd_val : '0;
    end
  end
  assign bus_resp_o   = r_resp;
  assign bus_rdata_bo = r_rdata;
endmodule
